gemm_tile_engine: RTL and testbench

- Parametrised successor to the tile compute engine.
- Accepts one TILE command and runs a B×C grid of dot products over V-line vectors.
- Reads left and right mantissa lines from the shared tile BRAM over a single read port, then writes one signed result per (b,c) pair into the result FIFO.
- Sits between the master control FSM (TILE command and done) and the result FIFO.

---
 rtl/gemm_pkg.sv | 37 +++
 rtl/gemm_tile_engine_if.sv | 24 ++
 rtl/gemm_line_dot.sv | 36 +++
 rtl/gemm_tile_engine.sv | 222 ++++++++++++++++++++++
 tb/tb_gemm_tile_engine.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_pkg.sv
// Shared definitions for the GEMM tile engine: FSM state encoding,
// accumulator sizing and the mantissa lane decode used by the dot-product datapath.
package gemm_pkg;

    localparam int MAX_MAN_W = 16;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_FETCH_L = 4'd1,
        ST_FETCH_R = 4'd2,
        ST_WAIT    = 4'd3,
        ST_MAC     = 4'd4,
        ST_EMIT    = 4'd5,
        ST_DONE    = 4'd6
    } gemm_tile_state_t;

    function automatic int ACC_W(input int man_w, input int lanes);
        return 2 * man_w + $clog2(lanes) + 8;
    endfunction

    // 4-bit mode keeps only the low nibble and sign-extends its bit 3.
    function automatic logic signed [MAX_MAN_W-1:0] decode_lane(
        input logic [MAX_MAN_W-1:0] field,
        input int                   man_w,
        input logic                 man_4b
    );
        logic signed [MAX_MAN_W-1:0] val;
        int msb;
        msb = man_4b ? 3 : man_w - 1;
        val = '0;
        for (int i = 0; i < MAX_MAN_W; i++) begin
            val[i] = (i <= msb) ? field[i] : field[msb];
        end
        return val;
    endfunction

endpackage

// File: rtl/gemm_tile_engine_if.sv
// Tile-engine data buses: BRAM read port and result FIFO write port.
// master = engine side, slave = memory/FIFO side.
interface gemm_tile_engine_if #(
    parameter int ADDR_W   = 11,
    parameter int LINE_W   = 256,
    parameter int RESULT_W = 24
);
    logic [ADDR_W-1:0]   o_bram_rd_addr;
    logic                o_bram_rd_en;
    logic [LINE_W-1:0]   i_bram_rd_data;
    logic [RESULT_W-1:0] o_result_data;
    logic                o_result_valid;
    logic                i_result_full;

    modport master (
        output o_bram_rd_addr, o_bram_rd_en, o_result_data, o_result_valid,
        input  i_bram_rd_data, i_result_full
    );

    modport slave (
        input  o_bram_rd_addr, o_bram_rd_en, o_result_data, o_result_valid,
        output i_bram_rd_data, i_result_full
    );
endinterface

// File: rtl/gemm_line_dot.sv
// Combinational dot product of two BRAM lines: per-lane decode, multiply and sum.
module gemm_line_dot
    import gemm_pkg::*;
#(
    parameter int LANES = 32,
    parameter int MAN_W = 8,
    parameter int DOT_W = 2 * MAN_W + $clog2(LANES)
) (
    input  logic [LANES*MAN_W-1:0] i_left_line,
    input  logic [LANES*MAN_W-1:0] i_right_line,
    input  logic                   i_left_man_4b,
    input  logic                   i_right_man_4b,
    output logic signed [DOT_W-1:0] o_dot
);

    logic signed [MAN_W-1:0]   lw;
    logic signed [MAN_W-1:0]   rw;
    logic signed [2*MAN_W-1:0] prod;
    logic signed [DOT_W-1:0]   sum;

    always_comb begin
        lw   = '0;
        rw   = '0;
        prod = '0;
        sum  = '0;
        for (int i = 0; i < LANES; i++) begin
            lw   = MAN_W'(decode_lane(MAX_MAN_W'(i_left_line[i*MAN_W +: MAN_W]), MAN_W, i_left_man_4b));
            rw   = MAN_W'(decode_lane(MAX_MAN_W'(i_right_line[i*MAN_W +: MAN_W]), MAN_W, i_right_man_4b));
            prod = lw * rw;
            sum  = sum + DOT_W'(prod);
        end
    end

    assign o_dot = sum;

endmodule

// File: rtl/gemm_tile_engine.sv
// Tile GEMM engine: dim_b x dim_c grid of dim_v-line dot products from tile BRAM into the
// result FIFO. Define GEMM_TILE_ENGINE_SAT_EN to saturate results instead of wrapping.
//   state   | meaning
//   IDLE    | wait for i_tile_en, latch command
//   FETCH_L | read left line
//   FETCH_R | read right line
//   WAIT    | RD_LAT cycles for read data
//   MAC     | accumulate line dot product
//   EMIT    | present result, hold while FIFO full
//   DONE    | one-cycle completion pulse
module gemm_tile_engine
    import gemm_pkg::*;
#(
    parameter int LANES    = 32,
    parameter int MAN_W    = 8,
    parameter int RESULT_W = 24,
    parameter int ADDR_W   = 11,
    parameter int RD_LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_tile_en,
    input  logic [ADDR_W-1:0] i_left_addr,
    input  logic [ADDR_W-1:0] i_right_addr,
    input  logic [7:0]        i_dim_b,
    input  logic [7:0]        i_dim_c,
    input  logic [7:0]        i_dim_v,
    input  logic              i_left_man_4b,
    input  logic              i_right_man_4b,
    input  logic              i_main_loop_over_left,
    output logic              o_tile_done,
    output logic [3:0]        o_ce_state,
    gemm_tile_engine_if.master bus
);

    localparam int LINE_W   = LANES * MAN_W;
    localparam int DOT_W    = 2 * MAN_W + $clog2(LANES);
    localparam int ACC_BITS = ACC_W(MAN_W, LANES);

    gemm_tile_state_t           state;
    logic [ADDR_W-1:0]          left_addr, right_addr;
    logic [ADDR_W-1:0]          left_base, right_base, left_ptr, right_ptr;
    logic [7:0]                 dim_b, dim_c, dim_v, b_cnt, c_cnt, v_cnt;
    logic                       left_man_4b, right_man_4b, loop_over_left;
    logic [1:0]                 wait_cnt;
    logic [LINE_W-1:0]          left_line, right_line;
    logic [RD_LAT-1:0]          pend_l, pend_r;
    logic signed [DOT_W-1:0]    dot;
    logic signed [ACC_BITS-1:0] acc, acc_base, acc_next;
    logic [RESULT_W-1:0]        result_q, result_next;
    logic                       b_last, c_last;

    gemm_line_dot #(
        .LANES (LANES),
        .MAN_W (MAN_W),
        .DOT_W (DOT_W)
    ) u_line_dot (
        .i_left_line    (left_line),
        .i_right_line   (right_line),
        .i_left_man_4b  (left_man_4b),
        .i_right_man_4b (right_man_4b),
        .o_dot          (dot)
    );

    assign b_last   = (b_cnt == dim_b - 8'd1);
    assign c_last   = (c_cnt == dim_c - 8'd1);
    assign acc_base = (v_cnt == 8'd0) ? '0 : acc;
    assign acc_next = acc_base + ACC_BITS'(dot);

`ifdef GEMM_TILE_ENGINE_SAT_EN
    localparam longint RES_MAX = (64'sd1 <<< (RESULT_W - 1)) - 64'sd1;
    localparam longint RES_MIN = -(64'sd1 <<< (RESULT_W - 1));

    always_comb begin
        result_next = acc_next[RESULT_W-1:0];
        if (acc_next > ACC_BITS'(RES_MAX)) begin
            result_next = RESULT_W'(RES_MAX);
        end else if (acc_next < ACC_BITS'(RES_MIN)) begin
            result_next = RESULT_W'(RES_MIN);
        end
    end
`else
    assign result_next = acc_next[RESULT_W-1:0];
`endif

    // Tag each issued read so its data is captured exactly RD_LAT cycles later.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            pend_l     <= '0;
            pend_r     <= '0;
            left_line  <= '0;
            right_line <= '0;
        end else begin
            pend_l <= RD_LAT'({pend_l, state == ST_FETCH_L});
            pend_r <= RD_LAT'({pend_r, state == ST_FETCH_R});
            if (pend_l[RD_LAT-1]) left_line  <= bus.i_bram_rd_data;
            if (pend_r[RD_LAT-1]) right_line <= bus.i_bram_rd_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state          <= ST_IDLE;
            left_addr      <= '0;
            right_addr     <= '0;
            left_base      <= '0;
            right_base     <= '0;
            left_ptr       <= '0;
            right_ptr      <= '0;
            dim_b          <= '0;
            dim_c          <= '0;
            dim_v          <= '0;
            b_cnt          <= '0;
            c_cnt          <= '0;
            v_cnt          <= '0;
            left_man_4b    <= 1'b0;
            right_man_4b   <= 1'b0;
            loop_over_left <= 1'b0;
            wait_cnt       <= '0;
            acc            <= '0;
            result_q       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tile_en) begin
                        left_addr      <= i_left_addr;
                        right_addr     <= i_right_addr;
                        left_base      <= i_left_addr;
                        right_base     <= i_right_addr;
                        left_ptr       <= i_left_addr;
                        right_ptr      <= i_right_addr;
                        dim_b          <= i_dim_b;
                        dim_c          <= i_dim_c;
                        dim_v          <= i_dim_v;
                        b_cnt          <= '0;
                        c_cnt          <= '0;
                        v_cnt          <= '0;
                        left_man_4b    <= i_left_man_4b;
                        right_man_4b   <= i_right_man_4b;
                        loop_over_left <= i_main_loop_over_left;
                        if (i_dim_b == 8'd0 || i_dim_c == 8'd0 || i_dim_v == 8'd0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FETCH_L;
                        end
                    end
                end
                ST_FETCH_L: state <= ST_FETCH_R;
                ST_FETCH_R: begin
                    wait_cnt <= 2'(RD_LAT - 1);
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        state <= ST_MAC;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                ST_MAC: begin
                    acc       <= acc_next;
                    left_ptr  <= left_ptr + 1'b1;
                    right_ptr <= right_ptr + 1'b1;
                    if (v_cnt == dim_v - 8'd1) begin
                        v_cnt    <= '0;
                        result_q <= result_next;
                        state    <= ST_EMIT;
                    end else begin
                        v_cnt <= v_cnt + 8'd1;
                        state <= ST_FETCH_L;
                    end
                end
                // Pointers sit one vector past their base here, which is the next row/column base.
                ST_EMIT: begin
                    if (!bus.i_result_full) begin
                        if (b_last && c_last) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_FETCH_L;
                            if (loop_over_left) begin
                                if (c_last) begin
                                    c_cnt      <= '0;
                                    b_cnt      <= b_cnt + 8'd1;
                                    left_base  <= left_ptr;
                                    right_base <= right_addr;
                                    right_ptr  <= right_addr;
                                end else begin
                                    c_cnt      <= c_cnt + 8'd1;
                                    right_base <= right_ptr;
                                    left_ptr   <= left_base;
                                end
                            end else begin
                                if (b_last) begin
                                    b_cnt      <= '0;
                                    c_cnt      <= c_cnt + 8'd1;
                                    right_base <= right_ptr;
                                    left_base  <= left_addr;
                                    left_ptr   <= left_addr;
                                end else begin
                                    b_cnt      <= b_cnt + 8'd1;
                                    left_base  <= left_ptr;
                                    right_ptr  <= right_base;
                                end
                            end
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_ce_state         = state;
    assign o_tile_done        = (state == ST_DONE);
    assign bus.o_bram_rd_en   = (state == ST_FETCH_L) || (state == ST_FETCH_R);
    assign bus.o_bram_rd_addr = (state == ST_FETCH_L) ? left_ptr :
                                (state == ST_FETCH_R) ? right_ptr : '0;
    assign bus.o_result_valid = (state == ST_EMIT) && !bus.i_result_full;
    assign bus.o_result_data  = result_q;

endmodule

// File: tb/tb_gemm_tile_engine.sv
// Scoreboard bench for gemm_tile_engine: a reference model computes each tile's read
// addresses and results from BRAM contents; monitors pop and compare as the DUT presents them.
module tb_gemm_tile_engine;

    localparam int LANES    = 32;
    localparam int MAN_W    = 8;
    localparam int RESULT_W = 24;
    localparam int ADDR_W   = 11;
    localparam int RD_LAT   = 1;
    localparam int LINE_W   = LANES * MAN_W;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int TMO      = 2000;
    localparam longint RES_MASK = (64'sd1 <<< RESULT_W) - 64'sd1;
    localparam longint RES_MAX  = (64'sd1 <<< (RESULT_W - 1)) - 64'sd1;
    localparam longint RES_MIN  = -(64'sd1 <<< (RESULT_W - 1));

    logic              clk = 1'b0;
    logic              reset_n;
    logic              tile_en;
    logic [ADDR_W-1:0] left_addr, right_addr;
    logic [7:0]        dim_b, dim_c, dim_v;
    logic              l4, r4, lol;
    logic              done;
    logic [3:0]        ce_state;
    logic              full_dir, full_rnd, rand_full_en;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rd_pipe [RD_LAT];

    int     n_checks = 0, n_fail = 0;
    int     n_res = 0, n_rd = 0, n_done = 0, cyc = 0;
    int     last_valid_cyc = 0, start_cyc = 0;
    longint last_result = 0;
    longint exp_q[$];
    int     addr_q[$];

    gemm_tile_engine_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .RESULT_W(RESULT_W)) bus();

    gemm_tile_engine #(
        .LANES(LANES), .MAN_W(MAN_W), .RESULT_W(RESULT_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)
    ) dut (
        .i_clk                 (clk),
        .i_reset_n             (reset_n),
        .i_tile_en             (tile_en),
        .i_left_addr           (left_addr),
        .i_right_addr          (right_addr),
        .i_dim_b               (dim_b),
        .i_dim_c               (dim_c),
        .i_dim_v               (dim_v),
        .i_left_man_4b         (l4),
        .i_right_man_4b        (r4),
        .i_main_loop_over_left (lol),
        .o_tile_done           (done),
        .o_ce_state            (ce_state),
        .bus                   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.o_bram_rd_addr];
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign bus.i_bram_rd_data = rd_pipe[RD_LAT-1];
    assign bus.i_result_full  = full_dir | full_rnd;

    initial begin
        full_rnd = 1'b0;
        forever begin
            @(posedge clk); #1;
            full_rnd = rand_full_en && ($urandom_range(0, 3) == 0);
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.o_result_valid) begin
            n_res++;
            last_valid_cyc = cyc;
            last_result    = longint'(bus.o_result_data);
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL result_unexpected: got 0x%0h, no result required", bus.o_result_data);
            end else begin
                check("result_data", longint'(bus.o_result_data), exp_q.pop_front());
            end
        end
        if (bus.o_bram_rd_en) begin
            n_rd++;
            if (addr_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL read_unexpected: got addr 0x%0h, no read required", bus.o_bram_rd_addr);
            end else begin
                check("read_addr", longint'(bus.o_bram_rd_addr), longint'(addr_q.pop_front()));
            end
        end
        if (done) n_done++;
    end

    function automatic int lane_val(input logic [LINE_W-1:0] line, input int idx, input bit is4);
        int x;
        x = int'(line[idx*MAN_W +: MAN_W]);
        if (is4) begin
            x = x % 16;
            if (x >= 8) x -= 16;
        end else if (x >= (1 << (MAN_W - 1))) begin
            x -= (1 << MAN_W);
        end
        return x;
    endfunction

    function automatic longint reduce(input longint s);
        longint r;
        r = s;
`ifdef GEMM_TILE_ENGINE_SAT_EN
        if (r > RES_MAX) r = RES_MAX;
        else if (r < RES_MIN) r = RES_MIN;
`endif
        return r & RES_MASK;
    endfunction

    // Reference: enumerate (b,c) in loop order, address = base + index*dim_v + v mod DEPTH.
    function automatic int model_tile(input int la, ra, db, dc, dv, input bit ml4, mr4, mlol);
        int n, b, c, al, ar;
        longint s;
        n = 0;
        if (db == 0 || dc == 0 || dv == 0) return 0;
        for (int o = 0; o < (mlol ? db : dc); o++) begin
            for (int i = 0; i < (mlol ? dc : db); i++) begin
                b = mlol ? o : i;
                c = mlol ? i : o;
                s = 0;
                for (int v = 0; v < dv; v++) begin
                    al = (la + b * dv + v) % DEPTH;
                    ar = (ra + c * dv + v) % DEPTH;
                    addr_q.push_back(al);
                    addr_q.push_back(ar);
                    for (int ln = 0; ln < LANES; ln++)
                        s += longint'(lane_val(mem[al], ln, ml4) * lane_val(mem[ar], ln, mr4));
                end
                exp_q.push_back(reduce(s));
                n++;
            end
        end
        return n;
    endfunction

    task automatic fill_line(input int a, input logic [7:0] val);
        for (int ln = 0; ln < LANES; ln++) mem[a][ln*MAN_W +: MAN_W] = MAN_W'(val);
    endtask

    task automatic start_tile(input int la, ra, db, dc, dv, input bit sl4, sr4, slol);
        @(posedge clk); #1;
        left_addr  = ADDR_W'(la);
        right_addr = ADDR_W'(ra);
        dim_b = 8'(db); dim_c = 8'(dc); dim_v = 8'(dv);
        l4 = sl4; r4 = sr4; lol = slol;
        tile_en = 1'b1;
        @(negedge clk);
        start_cyc = cyc;
        @(posedge clk); #1;
        tile_en = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < TMO && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", longint'(seen), 1);
    endtask

    task automatic run_tile(input int la, ra, db, dc, dv, input bit sl4, sr4, slol);
        int exp_n, res0, rd0;
        bit seen;
        exp_n = model_tile(la, ra, db, dc, dv, sl4, sr4, slol);
        res0 = n_res;
        rd0  = n_rd;
        start_tile(la, ra, db, dc, dv, sl4, sr4, slol);
        wait_done(seen);
        if (seen) begin
            if (exp_n == 0) check("done_latency_zero_dim", longint'(cyc - start_cyc), 1);
            else            check("done_latency", longint'(cyc - last_valid_cyc), 1);
        end
        check("result_count", longint'(n_res - res0), longint'(exp_n));
        check("read_count", longint'(n_rd - rd0), longint'(exp_n * dv * 2));
        @(negedge clk);
        check("done_width", longint'(done), 0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        bit seen;
        int res0, rd0, done0, db, dc, dv;

        reset_n = 1'b0; tile_en = 1'b0; left_addr = '0; right_addr = '0;
        dim_b = '0; dim_c = '0; dim_v = '0; l4 = 1'b0; r4 = 1'b0; lol = 1'b0;
        full_dir = 1'b0; rand_full_en = 1'b0;
        for (int a = 0; a < DEPTH; a++) mem[a] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", longint'(ce_state), 0);
        check("rst_rd_en", longint'(bus.o_bram_rd_en), 0);
        check("rst_rd_addr", longint'(bus.o_bram_rd_addr), 0);
        check("rst_valid", longint'(bus.o_result_valid), 0);
        check("rst_data", longint'(bus.o_result_data), 0);
        check("rst_done", longint'(done), 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        fill_line(16'h010, 8'h01);
        fill_line(16'h020, 8'h02);
        run_tile('h010, 'h020, 1, 1, 1, 0, 0, 1);
        check("basic_value", last_result, 'h000040);

        fill_line('h030, 8'h0F);
        fill_line('h031, 8'h03);
        run_tile('h030, 'h031, 1, 1, 1, 1, 0, 1);
        check("left_4b_value", last_result, 'hFFFFA0);
        run_tile('h030, 'h031, 1, 1, 1, 0, 0, 1);
        check("left_8b_value", last_result, 'h0005A0);

        for (int v = 0; v < 20; v++) begin
            fill_line('h100 + v, 8'h7F);
            fill_line('h200 + v, 8'h7F);
        end
        run_tile('h100, 'h200, 1, 1, 20, 0, 0, 1);
`ifdef GEMM_TILE_ENGINE_SAT_EN
        check("overflow_value", last_result, 'h7FFFFF);
`else
        check("overflow_value", last_result, 'h9D8280);
`endif

        // FIFO full for the first 5 EMIT cycles
        full_dir = 1'b1;
        void'(model_tile('h010, 'h020, 1, 1, 1, 0, 0, 1));
        res0 = n_res;
        start_tile('h010, 'h020, 1, 1, 1, 0, 0, 1);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (ce_state == 4'd5) seen = 1'b1;
        end
        check("full_emit_reached", longint'(seen), 1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("full_hold_state", longint'(ce_state), 5);
            check("full_hold_valid", longint'(bus.o_result_valid), 0);
            check("full_hold_data", longint'(bus.o_result_data), 'h000040);
        end
        @(posedge clk); #1;
        full_dir = 1'b0;
        wait_done(seen);
        check("full_one_result", longint'(n_res - res0), 1);
        exp_q.delete();
        addr_q.delete();

        run_tile('h010, 'h020, 1, 1, 0, 0, 0, 1);
        run_tile('h010, 'h020, 0, 2, 2, 0, 0, 1);
        run_tile('h010, 'h020, 3, 0, 1, 1, 1, 0);

        for (int a = 0; a < DEPTH; a++)
            for (int w = 0; w < LINE_W / 32; w++) mem[a][w*32 +: 32] = $urandom();
        run_tile('h000, 'h7FE, 2, 3, 2, 0, 0, 1);
        run_tile('h000, 'h7FE, 2, 3, 2, 0, 0, 0);
        run_tile('h7FF, 'h7FD, 3, 2, 3, 1, 1, 0);

        rand_full_en = 1'b1;
        for (int n = 0; n < 12; n++) begin
            db = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
            dc = int'($urandom_range(1, 3));
            dv = int'($urandom_range(1, 3));
            run_tile(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                     db, dc, dv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end
        rand_full_en = 1'b0;
        @(posedge clk);

        // Reset while waiting for read data
        void'(model_tile('h040, 'h050, 1, 1, 2, 0, 0, 1));
        start_tile('h040, 'h050, 1, 1, 2, 0, 0, 1);
        seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (ce_state == 4'd3) seen = 1'b1;
        end
        check("rst_wait_reached", longint'(seen), 1);
        reset_n = 1'b0;
        done0 = n_done;
        @(negedge clk);
        check("abort_state", longint'(ce_state), 0);
        check("abort_rd_en", longint'(bus.o_bram_rd_en), 0);
        check("abort_rd_addr", longint'(bus.o_bram_rd_addr), 0);
        check("abort_valid", longint'(bus.o_result_valid), 0);
        check("abort_data", longint'(bus.o_result_data), 0);
        check("abort_done", longint'(done), 0);
        exp_q.delete();
        addr_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        res0 = n_res;
        rd0  = n_rd;
        repeat (20) @(negedge clk);
        check("abort_no_done", longint'(n_done - done0), 0);
        check("abort_no_reads", longint'(n_rd - rd0), 0);
        check("abort_no_results", longint'(n_res - res0), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
